qpu_exu_alu_sched: RTL and testbench
====================================

Name: qpu_exu_alu_sched

Overview:
- Cycle-by-cycle scheduler that shares the single EXU ALU datapath among three requesters: ALU, BJP and QIU.
- Performs valid/ready arbitration and drives the one-hot datapath select plus operands/opcode.
- Captures the combinational datapath result into a 1-entry response buffer per requester, each with its own valid/ready handshake.
- Sits between the EXU dispatch/issue units and the ALU datapath.

Parameters:
STARVE_MAX, 4, consecutive BJP wins allowed while ALU/QIU is waiting before the round-robin winner is forced.
STARVE_W, 3, starvation counter width; must satisfy 2^STARVE_W > STARVE_MAX.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
alu_i_valid / alu_i_ready  in/out  1/1  ALU request handshake
alu_i_op1, alu_i_op2  input  QPU_XLEN  ALU operands
alu_i_add, alu_i_or, alu_i_xor, alu_i_and  input  1 each  ALU opcode, one-hot
alu_o_valid / alu_o_ready  out/in  1/1  ALU response handshake
alu_o_res  output  QPU_XLEN  ALU result
bjp_i_valid / bjp_i_ready  in/out  1/1  BJP request handshake
bjp_i_op1, bjp_i_op2  input  QPU_XLEN  compare operands
bjp_i_cmp_eq, bjp_i_cmp_ne, bjp_i_cmp_lt, bjp_i_cmp_gt  input  1 each  compare opcode, one-hot
bjp_o_valid / bjp_o_ready  out/in  1/1  BJP response handshake
bjp_o_cmp_res  output  1  compare outcome
qiu_i_valid / qiu_i_ready  in/out  1/1  QIU request handshake (always an add)
qiu_i_op1, qiu_i_op2  input  QPU_XLEN  QIU operands
qiu_o_valid / qiu_o_ready  out/in  1/1  QIU response handshake
qiu_o_res  output  QPU_XLEN  QIU result
dp_alu_sel, dp_bjp_sel, dp_qiu_sel  output  1 each  datapath requester select; at most one high
dp_alu_add, dp_alu_or, dp_alu_xor, dp_alu_and  output  1 each  pass-through ALU opcode, gated by dp_alu_sel
dp_alu_op1, dp_alu_op2  output  QPU_XLEN  ALU operands, gated by dp_alu_sel
dp_bjp_cmp_eq, dp_bjp_cmp_ne, dp_bjp_cmp_lt, dp_bjp_cmp_gt  output  1 each  compare opcode, gated by dp_bjp_sel
dp_bjp_op1, dp_bjp_op2  output  QPU_XLEN  compare operands, gated by dp_bjp_sel
dp_qiu_op1, dp_qiu_op2  output  QPU_XLEN  QIU operands, gated by dp_qiu_sel
dp_alu_res, dp_qiu_res  input  QPU_XLEN  datapath results
dp_bjp_cmp_res  input  1  datapath compare result

Behaviour:
- Eligibility: requester X is eligible when X_i_valid & (~X_o_valid | X_o_ready). A full response buffer that is drained in the same cycle frees its slot.
- Grant is combinational, at most one per cycle. X_i_ready = grant_X. A transfer happens on valid & ready.
- Priority: BJP beats ALU and QIU. Between ALU and QIU, the round-robin pointer rr (0 = ALU, 1 = QIU) selects. rr flips to the non-winner after every ALU or QIU grant.
- Starvation: starve_cnt increments on each BJP grant while an ALU or QIU request is pending but not granted. It clears on any ALU or QIU grant, and when no ALU/QIU request is pending.
  - When starve_cnt == STARVE_MAX, the ALU/QIU rr winner is granted over BJP.
  - The counter saturates; it never wraps.
- Datapath drive: dp_*_sel = grant_*. All operand and opcode outputs are zero when their select is low.
- Latency: one cycle. The result is registered at the grant edge. X_o_valid rises in the next cycle, holding X_o_res / bjp_o_cmp_res.
- Response buffer:
  - Set on grant.
  - Cleared on X_o_valid & X_o_ready without a simultaneous new grant.
  - On simultaneous pop and grant: stays valid and takes the new data.
  - While valid and not popped, data is held stable.
- Back-to-back grants to the same requester on consecutive cycles are allowed when its consumer holds o_ready high (full throughput).
- Idle: no valid requests means no sel, no state change, and no counter increment.
- Reset (async assert, clk-synchronous deassert handled upstream):
  - All *_o_valid = 0; results = 0; rr = 0; starve_cnt = 0.
  - A mid-operation reset drops any buffered response.
  - i_ready outputs are combinational and are 0 whenever no valid is present.
- Illegal opcode encodings (non-one-hot) are passed through unchanged. Not checked; assertion-only.

Decomposition:
- Shared package / QPU_defines.v: QPU_XLEN, requester index constants (REQ_ALU = 0, REQ_BJP = 1, REQ_QIU = 2), opcode field widths.
- Natural sub-module: qpu_exu_alu_sched_rspbuf, a 1-entry valid/data holding register parameterised by data width. It is instantiated three times (width QPU_XLEN, 1, QPU_XLEN).

Test Plan:
- ALU add alone: op1 = 5, op2 = 7, add = 1 → dp_alu_sel high the same cycle; next cycle alu_o_valid = 1, alu_o_res = 12.
- ALU, BJP (eq, 3 vs 3) and QIU (0x10 + 0x20) all valid in cycle 0, all o_ready = 1 → grants BJP, ALU, QIU in cycles 0/1/2; bjp_o_cmp_res = 1, qiu_o_res = 0x30.
- ALU and QIU continuously valid, no BJP → grants alternate ALU, QIU, ALU, QIU; each response valid every other cycle.
- alu_o_ready = 0 after the first ALU result, second ALU request valid → alu_i_ready stays 0 and alu_o_res holds. Raising alu_o_ready grants the new request the same cycle, and alu_o_valid stays high with the new data.
- BJP and ALU valid every cycle, STARVE_MAX = 4 → BJP wins 4 cycles, ALU is granted in cycle 4, then BJP resumes.
- rst_n asserted while qiu_o_valid = 1 → qiu_o_valid = 0 immediately (async); after release no response appears until a new grant.

Source files
------------

// File: rtl/qpu_exu_alu_sched_pkg.sv
// rtl/qpu_exu_alu_sched_pkg.sv - shared constants and types for the EXU ALU scheduler
package qpu_exu_alu_sched_pkg;

  localparam int QPU_XLEN = 32;

  // Requester indices, used wherever per-requester arrays are kept
  localparam int REQ_ALU = 0;
  localparam int REQ_BJP = 1;
  localparam int REQ_QIU = 2;
  localparam int REQ_NUM = 3;

  // Opcode field widths: {and, xor, or, add} and {gt, lt, ne, eq}
  localparam int ALU_OP_W = 4;
  localparam int BJP_OP_W = 4;

  // Round-robin pointer between the two fair requesters
  typedef enum logic [0:0] {
    RR_ALU = 1'b0,
    RR_QIU = 1'b1
  } rr_e;

endpackage

// File: rtl/qpu_exu_alu_sched_if.sv
// rtl/qpu_exu_alu_sched_if.sv - request, response and datapath signals of the ALU scheduler
interface qpu_exu_alu_sched_if;
  import qpu_exu_alu_sched_pkg::*;

  // ALU requester
  logic                alu_i_valid;
  logic                alu_i_ready;
  logic [QPU_XLEN-1:0] alu_i_op1;
  logic [QPU_XLEN-1:0] alu_i_op2;
  logic                alu_i_add;
  logic                alu_i_or;
  logic                alu_i_xor;
  logic                alu_i_and;
  logic                alu_o_valid;
  logic                alu_o_ready;
  logic [QPU_XLEN-1:0] alu_o_res;

  // BJP requester
  logic                bjp_i_valid;
  logic                bjp_i_ready;
  logic [QPU_XLEN-1:0] bjp_i_op1;
  logic [QPU_XLEN-1:0] bjp_i_op2;
  logic                bjp_i_cmp_eq;
  logic                bjp_i_cmp_ne;
  logic                bjp_i_cmp_lt;
  logic                bjp_i_cmp_gt;
  logic                bjp_o_valid;
  logic                bjp_o_ready;
  logic                bjp_o_cmp_res;

  // QIU requester
  logic                qiu_i_valid;
  logic                qiu_i_ready;
  logic [QPU_XLEN-1:0] qiu_i_op1;
  logic [QPU_XLEN-1:0] qiu_i_op2;
  logic                qiu_o_valid;
  logic                qiu_o_ready;
  logic [QPU_XLEN-1:0] qiu_o_res;

  // Shared datapath
  logic                dp_alu_sel;
  logic                dp_bjp_sel;
  logic                dp_qiu_sel;
  logic                dp_alu_add;
  logic                dp_alu_or;
  logic                dp_alu_xor;
  logic                dp_alu_and;
  logic [QPU_XLEN-1:0] dp_alu_op1;
  logic [QPU_XLEN-1:0] dp_alu_op2;
  logic                dp_bjp_cmp_eq;
  logic                dp_bjp_cmp_ne;
  logic                dp_bjp_cmp_lt;
  logic                dp_bjp_cmp_gt;
  logic [QPU_XLEN-1:0] dp_bjp_op1;
  logic [QPU_XLEN-1:0] dp_bjp_op2;
  logic [QPU_XLEN-1:0] dp_qiu_op1;
  logic [QPU_XLEN-1:0] dp_qiu_op2;
  logic [QPU_XLEN-1:0] dp_alu_res;
  logic [QPU_XLEN-1:0] dp_qiu_res;
  logic                dp_bjp_cmp_res;

  // Scheduler view
  modport slave (
    input  alu_i_valid, alu_i_op1, alu_i_op2, alu_i_add, alu_i_or, alu_i_xor, alu_i_and, alu_o_ready,
    output alu_i_ready, alu_o_valid, alu_o_res,
    input  bjp_i_valid, bjp_i_op1, bjp_i_op2, bjp_i_cmp_eq, bjp_i_cmp_ne, bjp_i_cmp_lt, bjp_i_cmp_gt,
    input  bjp_o_ready,
    output bjp_i_ready, bjp_o_valid, bjp_o_cmp_res,
    input  qiu_i_valid, qiu_i_op1, qiu_i_op2, qiu_o_ready,
    output qiu_i_ready, qiu_o_valid, qiu_o_res,
    output dp_alu_sel, dp_bjp_sel, dp_qiu_sel,
    output dp_alu_add, dp_alu_or, dp_alu_xor, dp_alu_and, dp_alu_op1, dp_alu_op2,
    output dp_bjp_cmp_eq, dp_bjp_cmp_ne, dp_bjp_cmp_lt, dp_bjp_cmp_gt, dp_bjp_op1, dp_bjp_op2,
    output dp_qiu_op1, dp_qiu_op2,
    input  dp_alu_res, dp_qiu_res, dp_bjp_cmp_res
  );

  // Requesters plus datapath view
  modport master (
    output alu_i_valid, alu_i_op1, alu_i_op2, alu_i_add, alu_i_or, alu_i_xor, alu_i_and, alu_o_ready,
    input  alu_i_ready, alu_o_valid, alu_o_res,
    output bjp_i_valid, bjp_i_op1, bjp_i_op2, bjp_i_cmp_eq, bjp_i_cmp_ne, bjp_i_cmp_lt, bjp_i_cmp_gt,
    output bjp_o_ready,
    input  bjp_i_ready, bjp_o_valid, bjp_o_cmp_res,
    output qiu_i_valid, qiu_i_op1, qiu_i_op2, qiu_o_ready,
    input  qiu_i_ready, qiu_o_valid, qiu_o_res,
    input  dp_alu_sel, dp_bjp_sel, dp_qiu_sel,
    input  dp_alu_add, dp_alu_or, dp_alu_xor, dp_alu_and, dp_alu_op1, dp_alu_op2,
    input  dp_bjp_cmp_eq, dp_bjp_cmp_ne, dp_bjp_cmp_lt, dp_bjp_cmp_gt, dp_bjp_op1, dp_bjp_op2,
    input  dp_qiu_op1, dp_qiu_op2,
    output dp_alu_res, dp_qiu_res, dp_bjp_cmp_res
  );

endinterface

// File: rtl/qpu_exu_alu_sched_rspbuf.sv
// rtl/qpu_exu_alu_sched_rspbuf.sv - one-entry response holding register with valid/ready output
module qpu_exu_alu_sched_rspbuf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  // A load wins over a pop so a drained slot refilled in the same cycle stays valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= din;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qpu_exu_alu_sched.sv
// rtl/qpu_exu_alu_sched.sv - arbitrates ALU, BJP and QIU onto the shared ALU datapath
module qpu_exu_alu_sched
  import qpu_exu_alu_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int STARVE_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qpu_exu_alu_sched_if.slave   io
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  rr_e                 rr;
  logic [STARVE_W-1:0] starve_cnt;

  logic elig_alu;
  logic elig_bjp;
  logic elig_qiu;
  logic aq_elig;
  logic aq_pick_qiu;
  logic force_aq;
  logic grant_alu;
  logic grant_bjp;
  logic grant_qiu;

  // A requester may go when its response slot is empty or being drained this cycle
  assign elig_alu = io.alu_i_valid && (!io.alu_o_valid || io.alu_o_ready);
  assign elig_bjp = io.bjp_i_valid && (!io.bjp_o_valid || io.bjp_o_ready);
  assign elig_qiu = io.qiu_i_valid && (!io.qiu_o_valid || io.qiu_o_ready);

  // BJP has priority unless ALU/QIU has been starved for STARVE_MAX BJP wins
  assign aq_elig     = elig_alu || elig_qiu;
  assign aq_pick_qiu = elig_qiu && (!elig_alu || (rr == RR_QIU));
  assign force_aq    = aq_elig && (starve_cnt == STARVE_LIM);
  assign grant_bjp   = elig_bjp && !force_aq;
  assign grant_qiu   = aq_elig && !grant_bjp && aq_pick_qiu;
  assign grant_alu   = aq_elig && !grant_bjp && !aq_pick_qiu;

  assign io.alu_i_ready = grant_alu;
  assign io.bjp_i_ready = grant_bjp;
  assign io.qiu_i_ready = grant_qiu;

  assign io.dp_alu_sel = grant_alu;
  assign io.dp_bjp_sel = grant_bjp;
  assign io.dp_qiu_sel = grant_qiu;

  // Operands and opcodes reach the datapath only for the granted requester
  assign io.dp_alu_add    = grant_alu && io.alu_i_add;
  assign io.dp_alu_or     = grant_alu && io.alu_i_or;
  assign io.dp_alu_xor    = grant_alu && io.alu_i_xor;
  assign io.dp_alu_and    = grant_alu && io.alu_i_and;
  assign io.dp_alu_op1    = grant_alu ? io.alu_i_op1 : '0;
  assign io.dp_alu_op2    = grant_alu ? io.alu_i_op2 : '0;
  assign io.dp_bjp_cmp_eq = grant_bjp && io.bjp_i_cmp_eq;
  assign io.dp_bjp_cmp_ne = grant_bjp && io.bjp_i_cmp_ne;
  assign io.dp_bjp_cmp_lt = grant_bjp && io.bjp_i_cmp_lt;
  assign io.dp_bjp_cmp_gt = grant_bjp && io.bjp_i_cmp_gt;
  assign io.dp_bjp_op1    = grant_bjp ? io.bjp_i_op1 : '0;
  assign io.dp_bjp_op2    = grant_bjp ? io.bjp_i_op2 : '0;
  assign io.dp_qiu_op1    = grant_qiu ? io.qiu_i_op1 : '0;
  assign io.dp_qiu_op2    = grant_qiu ? io.qiu_i_op2 : '0;

  // Round-robin pointer moves to the loser after each ALU or QIU grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= RR_ALU;
    end else if (grant_alu) begin
      rr <= RR_QIU;
    end else if (grant_qiu) begin
      rr <= RR_ALU;
    end
  end

  // Count BJP wins over a waiting ALU/QIU; saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_alu || grant_qiu || !aq_elig) begin
      starve_cnt <= '0;
    end else if (grant_bjp && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  qpu_exu_alu_sched_rspbuf #(.W(QPU_XLEN)) u_alu_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grant_alu),
    .din     (io.dp_alu_res),
    .o_ready (io.alu_o_ready),
    .o_valid (io.alu_o_valid),
    .o_data  (io.alu_o_res)
  );

  qpu_exu_alu_sched_rspbuf #(.W(1)) u_bjp_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grant_bjp),
    .din     (io.dp_bjp_cmp_res),
    .o_ready (io.bjp_o_ready),
    .o_valid (io.bjp_o_valid),
    .o_data  (io.bjp_o_cmp_res)
  );

  qpu_exu_alu_sched_rspbuf #(.W(QPU_XLEN)) u_qiu_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grant_qiu),
    .din     (io.dp_qiu_res),
    .o_ready (io.qiu_o_ready),
    .o_valid (io.qiu_o_valid),
    .o_data  (io.qiu_o_res)
  );

  // Opcodes are expected one-hot; the scheduler itself passes them through untouched
  a_alu_op_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    io.alu_i_valid |-> $onehot({io.alu_i_and, io.alu_i_xor, io.alu_i_or, io.alu_i_add}));
  a_bjp_op_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    io.bjp_i_valid |-> $onehot({io.bjp_i_cmp_gt, io.bjp_i_cmp_lt, io.bjp_i_cmp_ne, io.bjp_i_cmp_eq}));

endmodule

// File: tb/tb_qpu_exu_alu_sched.sv
// tb/tb_qpu_exu_alu_sched.sv - randomized scoreboard bench for the EXU ALU scheduler
module tb_qpu_exu_alu_sched;
  import qpu_exu_alu_sched_pkg::*;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpu_exu_alu_sched_if bus();

  qpu_exu_alu_sched #(.STARVE_MAX(SMAX), .STARVE_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  // Environment datapath: each requester has its own function unit behaviour
  assign bus.dp_alu_res = bus.dp_alu_add ? bus.dp_alu_op1 + bus.dp_alu_op2 :
                          bus.dp_alu_or  ? bus.dp_alu_op1 | bus.dp_alu_op2 :
                          bus.dp_alu_xor ? bus.dp_alu_op1 ^ bus.dp_alu_op2 :
                          bus.dp_alu_and ? bus.dp_alu_op1 & bus.dp_alu_op2 : '0;
  assign bus.dp_bjp_cmp_res = bus.dp_bjp_cmp_eq ? (bus.dp_bjp_op1 == bus.dp_bjp_op2) :
                              bus.dp_bjp_cmp_ne ? (bus.dp_bjp_op1 != bus.dp_bjp_op2) :
                              bus.dp_bjp_cmp_lt ? (bus.dp_bjp_op1 <  bus.dp_bjp_op2) :
                              bus.dp_bjp_cmp_gt ? (bus.dp_bjp_op1 >  bus.dp_bjp_op2) : 1'b0;
  assign bus.dp_qiu_res = bus.dp_qiu_op1 + bus.dp_qiu_op2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: pending requests, response-slot occupancy, fairness
  logic                rv[REQ_NUM];
  logic [QPU_XLEN-1:0] rop1[REQ_NUM];
  logic [QPU_XLEN-1:0] rop2[REQ_NUM];
  logic [3:0]          rop[REQ_NUM];
  logic                ordy[REQ_NUM];
  logic                occ[REQ_NUM];
  logic                g[REQ_NUM];
  logic                e[REQ_NUM];
  int                  rr_qiu_next;
  int                  starve;

  logic [QPU_XLEN-1:0] q_alu[$];
  logic                q_bjp[$];
  logic [QPU_XLEN-1:0] q_qiu[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [QPU_XLEN-1:0] alu_ref(input logic [3:0] op, input logic [QPU_XLEN-1:0] a,
                                                  input logic [QPU_XLEN-1:0] b);
    case (op)
      4'b0001: return a + b;
      4'b0010: return a | b;
      4'b0100: return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic bjp_ref(input logic [3:0] op, input logic [QPU_XLEN-1:0] a,
                                   input logic [QPU_XLEN-1:0] b);
    case (op)
      4'b0001: return a == b;
      4'b0010: return a != b;
      4'b0100: return a < b;
      default: return a > b;
    endcase
  endfunction

  task automatic drive();
    bus.alu_i_valid = rv[REQ_ALU];
    bus.alu_i_op1   = rop1[REQ_ALU];
    bus.alu_i_op2   = rop2[REQ_ALU];
    {bus.alu_i_and, bus.alu_i_xor, bus.alu_i_or, bus.alu_i_add} = rop[REQ_ALU];
    bus.bjp_i_valid = rv[REQ_BJP];
    bus.bjp_i_op1   = rop1[REQ_BJP];
    bus.bjp_i_op2   = rop2[REQ_BJP];
    {bus.bjp_i_cmp_gt, bus.bjp_i_cmp_lt, bus.bjp_i_cmp_ne, bus.bjp_i_cmp_eq} = rop[REQ_BJP];
    bus.qiu_i_valid = rv[REQ_QIU];
    bus.qiu_i_op1   = rop1[REQ_QIU];
    bus.qiu_i_op2   = rop2[REQ_QIU];
    bus.alu_o_ready = ordy[REQ_ALU];
    bus.bjp_o_ready = ordy[REQ_BJP];
    bus.qiu_o_ready = ordy[REQ_QIU];
  endtask

  task automatic model_clear();
    for (int i = 0; i < REQ_NUM; i++) begin
      rv[i] = 1'b0; rop1[i] = '0; rop2[i] = '0; rop[i] = 4'b0001;
      ordy[i] = 1'b0; occ[i] = 1'b0; g[i] = 1'b0; e[i] = 1'b0;
    end
    rr_qiu_next = 0;
    starve = 0;
    q_alu.delete();
    q_bjp.delete();
    q_qiu.delete();
  endtask

  // One clock per iteration: predict and check at negedge, update model at posedge, restimulate
  task automatic run_cycles(input int n, input int pv, input int pr, input logic [2:0] mask);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < REQ_NUM; i++) begin
        e[i] = rv[i] && (!occ[i] || ordy[i]);
        g[i] = 1'b0;
      end
      if (e[REQ_BJP] && !((e[REQ_ALU] || e[REQ_QIU]) && starve == SMAX)) g[REQ_BJP] = 1'b1;
      else if (e[REQ_ALU] && e[REQ_QIU]) g[rr_qiu_next ? REQ_QIU : REQ_ALU] = 1'b1;
      else if (e[REQ_ALU]) g[REQ_ALU] = 1'b1;
      else if (e[REQ_QIU]) g[REQ_QIU] = 1'b1;

      chk("alu_i_ready", bus.alu_i_ready, g[REQ_ALU]);
      chk("bjp_i_ready", bus.bjp_i_ready, g[REQ_BJP]);
      chk("qiu_i_ready", bus.qiu_i_ready, g[REQ_QIU]);
      chk("dp_alu_sel", bus.dp_alu_sel, g[REQ_ALU]);
      chk("dp_bjp_sel", bus.dp_bjp_sel, g[REQ_BJP]);
      chk("dp_qiu_sel", bus.dp_qiu_sel, g[REQ_QIU]);
      chk("alu_o_valid", bus.alu_o_valid, occ[REQ_ALU]);
      chk("bjp_o_valid", bus.bjp_o_valid, occ[REQ_BJP]);
      chk("qiu_o_valid", bus.qiu_o_valid, occ[REQ_QIU]);
      chk("dp_alu_op1", bus.dp_alu_op1, g[REQ_ALU] ? rop1[REQ_ALU] : '0);
      chk("dp_alu_op2", bus.dp_alu_op2, g[REQ_ALU] ? rop2[REQ_ALU] : '0);
      chk("dp_alu_opc", {bus.dp_alu_and, bus.dp_alu_xor, bus.dp_alu_or, bus.dp_alu_add},
          g[REQ_ALU] ? rop[REQ_ALU] : 4'b0);
      chk("dp_bjp_op1", bus.dp_bjp_op1, g[REQ_BJP] ? rop1[REQ_BJP] : '0);
      chk("dp_bjp_op2", bus.dp_bjp_op2, g[REQ_BJP] ? rop2[REQ_BJP] : '0);
      chk("dp_bjp_opc", {bus.dp_bjp_cmp_gt, bus.dp_bjp_cmp_lt, bus.dp_bjp_cmp_ne, bus.dp_bjp_cmp_eq},
          g[REQ_BJP] ? rop[REQ_BJP] : 4'b0);
      chk("dp_qiu_op1", bus.dp_qiu_op1, g[REQ_QIU] ? rop1[REQ_QIU] : '0);
      chk("dp_qiu_op2", bus.dp_qiu_op2, g[REQ_QIU] ? rop2[REQ_QIU] : '0);

      @(posedge clk);
      if (g[REQ_ALU]) q_alu.push_back(alu_ref(rop[REQ_ALU], rop1[REQ_ALU], rop2[REQ_ALU]));
      if (g[REQ_BJP]) q_bjp.push_back(bjp_ref(rop[REQ_BJP], rop1[REQ_BJP], rop2[REQ_BJP]));
      if (g[REQ_QIU]) q_qiu.push_back(rop1[REQ_QIU] + rop2[REQ_QIU]);
      for (int i = 0; i < REQ_NUM; i++) begin
        if (g[i]) occ[i] = 1'b1;
        else if (occ[i] && ordy[i]) occ[i] = 1'b0;
      end
      if (g[REQ_ALU]) rr_qiu_next = 1;
      if (g[REQ_QIU]) rr_qiu_next = 0;
      if (g[REQ_ALU] || g[REQ_QIU] || !(e[REQ_ALU] || e[REQ_QIU])) starve = 0;
      else if (g[REQ_BJP] && starve < SMAX) starve++;

      #1;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (g[i]) rv[i] = 1'b0;
        if (!rv[i] && mask[i] && ($urandom_range(99) < pv)) begin
          rv[i]   = 1'b1;
          rop1[i] = ($urandom_range(3) == 0) ? QPU_XLEN'($urandom_range(15)) : $urandom;
          rop2[i] = ($urandom_range(3) == 0) ? rop1[i] : $urandom;
          rop[i]  = 4'b0001 << $urandom_range(3);
        end
        ordy[i] = ($urandom_range(99) < pr);
      end
      drive();
    end
  endtask

  // Monitor: every accepted response is matched against the oldest expected one
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.alu_o_valid && bus.alu_o_ready) begin
          if (q_alu.size() == 0) chk("alu_rsp_unexpected", 64'd1, 64'd0);
          else chk("alu_o_res", bus.alu_o_res, q_alu.pop_front());
        end
        if (bus.bjp_o_valid && bus.bjp_o_ready) begin
          if (q_bjp.size() == 0) chk("bjp_rsp_unexpected", 64'd1, 64'd0);
          else chk("bjp_o_cmp_res", bus.bjp_o_cmp_res, q_bjp.pop_front());
        end
        if (bus.qiu_o_valid && bus.qiu_o_ready) begin
          if (q_qiu.size() == 0) chk("qiu_rsp_unexpected", 64'd1, 64'd0);
          else chk("qiu_o_res", bus.qiu_o_res, q_qiu.pop_front());
        end
      end
    end
  end

  initial begin
    model_clear();
    drive();
    #2;
    chk("rst_alu_o_valid", bus.alu_o_valid, 1'b0);
    chk("rst_bjp_o_valid", bus.bjp_o_valid, 1'b0);
    chk("rst_qiu_o_valid", bus.qiu_o_valid, 1'b0);
    chk("rst_alu_o_res", bus.alu_o_res, '0);
    chk("rst_bjp_o_cmp_res", bus.bjp_o_cmp_res, 1'b0);
    chk("rst_qiu_o_res", bus.qiu_o_res, '0);
    chk("rst_i_ready", {bus.alu_i_ready, bus.bjp_i_ready, bus.qiu_i_ready}, 3'b000);
    @(posedge clk);
    #3 rst_n = 1'b1;

    run_cycles(5, 0, 100, 3'b000);
    run_cycles(30, 100, 100, 3'b011);
    run_cycles(30, 100, 100, 3'b101);
    run_cycles(30, 100, 100, 3'b111);
    run_cycles(300, 60, 70, 3'b111);
    run_cycles(200, 90, 30, 3'b111);

    // Mid-operation reset with a QIU response held in its buffer
    run_cycles(8, 0, 100, 3'b000);
    run_cycles(3, 100, 0, 3'b100);
    chk("pre_rst_qiu_o_valid", bus.qiu_o_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_qiu_o_valid", bus.qiu_o_valid, 1'b0);
    chk("rst_async_qiu_o_res", bus.qiu_o_res, '0);
    model_clear();
    drive();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_cycles(4, 0, 100, 3'b000);

    run_cycles(300, 75, 60, 3'b111);
    run_cycles(10, 0, 100, 3'b000);
    chk("end_alu_q_empty", 64'(q_alu.size()), 64'd0);
    chk("end_bjp_q_empty", 64'(q_bjp.size()), 64'd0);
    chk("end_qiu_q_empty", 64'(q_qiu.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
